// File: rtl/ysyx_23060191_mc_core.sv
// Multi-cycle RV32I/E subset core: FETCH/EXEC/HALT control over a valid/response
// instruction fetch port, with an internal register file and halt/illegal status.
module ysyx_23060191_mc_core #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  output logic            retire,
  output logic [XLEN-1:0] retire_pc,
  output logic            halt,
  output logic [XLEN-1:0] halt_code,
  output logic            illegal
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc;
  logic [31:0]       ir;
  logic [XLEN-1:0]   gpr [NREG];
  logic [XLEN-1:0]   halt_code_q;
  logic              illegal_q;

  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm_i, imm_u, imm_j;
  logic [XLEN-1:0]   rs1_val, rs2_val, pc_plus4, jalr_sum;
  logic [XLEN-1:0]   next_pc, wb_data;
  logic              wb_en, legal, is_ebreak, uses_rs1, uses_rs2, bad_idx, exec_illegal;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

  // Out-of-range indices read as zero; such instructions are flagged illegal anyway.
  assign rs1_val  = (rs1 == 5'd0 || 32'(rs1) >= NREG) ? '0 : gpr[rs1[AW-1:0]];
  assign rs2_val  = (rs2 == 5'd0 || 32'(rs2) >= NREG) ? '0 : gpr[rs2[AW-1:0]];
  assign pc_plus4 = pc + XLEN'(4);
  assign jalr_sum = rs1_val + imm_i;

  always_comb begin
    wb_en     = 1'b0;
    wb_data   = '0;
    next_pc   = pc_plus4;
    legal     = 1'b0;
    is_ebreak = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      7'b0110111: begin legal = 1'b1; wb_en = 1'b1; wb_data = imm_u; end
      7'b0010111: begin legal = 1'b1; wb_en = 1'b1; wb_data = pc + imm_u; end
      7'b1101111: begin
        legal = 1'b1; wb_en = 1'b1; wb_data = pc_plus4; next_pc = pc + imm_j;
      end
      7'b1100111: if (funct3 == 3'b000) begin
        legal = 1'b1; wb_en = 1'b1; uses_rs1 = 1'b1; wb_data = pc_plus4;
        next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      end
      7'b0010011: if (funct3 == 3'b000) begin
        legal = 1'b1; wb_en = 1'b1; uses_rs1 = 1'b1; wb_data = rs1_val + imm_i;
      end
      7'b0110011: if (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) begin
        legal = 1'b1; wb_en = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        wb_data = funct7[5] ? rs1_val - rs2_val : rs1_val + rs2_val;
      end
      7'b1110011: if (ir == 32'h0010_0073) begin
        legal = 1'b1; is_ebreak = 1'b1; next_pc = pc;
      end
      default: ;
    endcase
    bad_idx = (wb_en    && 32'(rd)  >= NREG) ||
              (uses_rs1 && 32'(rs1) >= NREG) ||
              (uses_rs2 && 32'(rs2) >= NREG);
    exec_illegal = !legal || bad_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    ifu_req_valid = 1'b0;
    retire        = 1'b0;
    case (state)
      S_FETCH: begin
        ifu_req_valid = !rst;
        if (ifu_rsp_valid) state_n = S_EXEC;
      end
      S_EXEC: begin
        retire  = !exec_illegal;
        state_n = (exec_illegal || is_ebreak) ? S_HALT : S_FETCH;
      end
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= XLEN'(RESET_PC);
      ir          <= '0;
      halt_code_q <= '0;
      illegal_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (ifu_rsp_valid) ir <= ifu_rsp_inst;
        S_EXEC: begin
          if (exec_illegal) begin
            illegal_q   <= 1'b1;
            halt_code_q <= '0;
          end else begin
            pc <= next_pc;
            if (wb_en && rd != 5'd0) gpr[rd[AW-1:0]] <= wb_data;
            if (is_ebreak) halt_code_q <= gpr[AW'(10)];
          end
        end
        default: ;
      endcase
    end
  end

  assign ifu_req_addr = pc;
  assign retire_pc    = retire ? pc : '0;
  assign halt         = (state == S_HALT);
  assign halt_code    = halt_code_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_ysyx_23060191_mc_core.sv
// Directed bench for ysyx_23060191_mc_core: instruction tables applied through the
// fetch handshake, plus hand-written halt, RV32E-illegal and mid-operation reset cases.
module tb_ysyx_23060191_mc_core;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_inst = '0;
  logic        sel_e = 1'b0;

  logic        m_valid, m_retire, m_halt, m_illegal;
  logic [31:0] m_addr, m_retire_pc, m_code;
  logic        e_valid, e_retire, e_halt, e_illegal;
  logic [31:0] e_addr, e_retire_pc, e_code;
  logic        o_valid, o_retire, o_halt, o_illegal;
  logic [31:0] o_addr, o_retire_pc, o_code;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    int          stall;
    logic [31:0] addr;
    bit          ret;
  } vec_t;

  vec_t prog[$];

  always #5 clk = ~clk;

  ysyx_23060191_mc_core #(.XLEN(32), .NREG(32), .RESET_PC(32'h8000_0000)) u_main (
    .clk(clk), .rst(rst),
    .ifu_req_valid(m_valid), .ifu_req_addr(m_addr),
    .ifu_rsp_valid(rsp_valid), .ifu_rsp_inst(rsp_inst),
    .retire(m_retire), .retire_pc(m_retire_pc),
    .halt(m_halt), .halt_code(m_code), .illegal(m_illegal)
  );

  ysyx_23060191_mc_core #(.XLEN(32), .NREG(16), .RESET_PC(32'h8000_0000)) u_rv32e (
    .clk(clk), .rst(rst),
    .ifu_req_valid(e_valid), .ifu_req_addr(e_addr),
    .ifu_rsp_valid(rsp_valid), .ifu_rsp_inst(rsp_inst),
    .retire(e_retire), .retire_pc(e_retire_pc),
    .halt(e_halt), .halt_code(e_code), .illegal(e_illegal)
  );

  always_comb begin
    o_valid     = sel_e ? e_valid     : m_valid;
    o_addr      = sel_e ? e_addr      : m_addr;
    o_retire    = sel_e ? e_retire    : m_retire;
    o_retire_pc = sel_e ? e_retire_pc : m_retire_pc;
    o_halt      = sel_e ? e_halt      : m_halt;
    o_code      = sel_e ? e_code      : m_code;
    o_illegal   = sel_e ? e_illegal   : m_illegal;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rsp_valid = 1'b0;
    rsp_inst  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Entered at a sampling point in FETCH; leaves one cycle after the EXEC cycle.
  task automatic run_inst(input vec_t v);
    chk("req_valid", 32'(o_valid), 32'd1);
    chk("req_addr", o_addr, v.addr);
    chk("retire_in_fetch", 32'(o_retire), 32'd0);
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_addr", o_addr, v.addr);
      chk("stall_retire", 32'(o_retire), 32'd0);
    end
    rsp_valid = 1'b1;
    rsp_inst  = v.inst;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_inst  = '0;
    chk("retire", 32'(o_retire), 32'(v.ret));
    chk("retire_pc", o_retire_pc, v.ret ? v.addr : 32'h0);
    @(negedge clk);
  endtask

  task automatic run_prog();
    foreach (prog[i]) run_inst(prog[i]);
    prog.delete();
  endtask

  task automatic check_halted(input logic [31:0] code, input bit ill);
    chk("halt", 32'(o_halt), 32'd1);
    chk("halt_code", o_code, code);
    chk("illegal", 32'(o_illegal), 32'(ill));
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1'b1;
      rsp_inst  = 32'h0050_0093;
      @(negedge clk);
      chk("halt_req_valid", 32'(o_valid), 32'd0);
      chk("halt_retire", 32'(o_retire), 32'd0);
      chk("halt_sticky", 32'(o_halt), 32'd1);
      chk("illegal_sticky", 32'(o_illegal), 32'(ill));
    end
    rsp_valid = 1'b0;
    rsp_inst  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_req_valid", 32'(o_valid), 32'd0);
    chk("rst_retire", 32'(o_retire), 32'd0);
    chk("rst_retire_pc", o_retire_pc, 32'h0);
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_halt_code", o_code, 32'h0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);

    // ADDI chain, rd==rs1, result observed through EBREAK a0
    do_reset();
    prog.push_back('{32'h0050_0093, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{32'hFF90_8093, 0, 32'h8000_0004, 1'b1});
    prog.push_back('{32'h0000_8513, 0, 32'h8000_0008, 1'b1});
    prog.push_back('{EBREAK,        0, 32'h8000_000C, 1'b1});
    run_prog();
    check_halted(32'hFFFF_FFFE, 1'b0);

    // JAL, JALR with bit-0 clear and x0 write discarded, stalled fetch
    do_reset();
    prog.push_back('{32'h0080_00EF, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{32'h0030_8067, 0, 32'h8000_0008, 1'b1});
    prog.push_back('{32'h0000_8533, 3, 32'h8000_0006, 1'b1});
    prog.push_back('{EBREAK,        0, 32'h8000_000A, 1'b1});
    run_prog();
    check_halted(32'h8000_0004, 1'b0);

    // LUI, AUIPC, SUB
    do_reset();
    prog.push_back('{32'h1234_5137, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{32'h0000_1197, 0, 32'h8000_0004, 1'b1});
    prog.push_back('{32'h4021_8533, 0, 32'h8000_0008, 1'b1});
    prog.push_back('{EBREAK,        0, 32'h8000_000C, 1'b1});
    run_prog();
    check_halted(32'h6DCB_C004, 1'b0);

    // All-zero word is illegal; halt_code is 0 even though a0 holds 42
    do_reset();
    prog.push_back('{32'h02A0_0513, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{32'h0000_0000, 0, 32'h8000_0004, 1'b0});
    run_prog();
    check_halted(32'h0, 1'b1);

    // RV32E instance: legal EBREAK with a0=42
    sel_e = 1'b1;
    do_reset();
    prog.push_back('{32'h02A0_0513, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{EBREAK,        0, 32'h8000_0004, 1'b1});
    run_prog();
    check_halted(32'd42, 1'b0);

    // RV32E instance: x17 destination is illegal
    do_reset();
    prog.push_back('{32'h0030_0793, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{32'h0010_0893, 0, 32'h8000_0004, 1'b0});
    run_prog();
    check_halted(32'h0, 1'b1);
    sel_e = 1'b0;

    // Reset during a stalled fetch at 0x8000_0010, with a late response offered
    do_reset();
    for (int i = 0; i < 4; i++)
      prog.push_back('{32'h0050_0093, 0, 32'h8000_0000 + 32'(4 * i), 1'b1});
    run_prog();
    chk("mid_fetch_addr", o_addr, 32'h8000_0010);
    repeat (2) @(negedge clk);
    chk("mid_fetch_valid", 32'(o_valid), 32'd1);
    #2;
    rst = 1'b1;
    rsp_valid = 1'b1;
    rsp_inst  = EBREAK;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_retire", 32'(o_retire), 32'd0);
    chk("async_rst_retire_pc", o_retire_pc, 32'h0);
    chk("async_rst_halt", 32'(o_halt), 32'd0);
    chk("async_rst_code", o_code, 32'h0);
    chk("async_rst_illegal", 32'(o_illegal), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(o_valid), 32'd0);
    rsp_valid = 1'b0;
    rsp_inst  = '0;
    rst = 1'b0;
    #1;

    // Reset during EXEC kills the retire pulse immediately
    run_inst('{32'h0050_0093, 0, 32'h8000_0000, 1'b1});
    chk("pre_exec_addr", o_addr, 32'h8000_0004);
    rsp_valid = 1'b1;
    rsp_inst  = EBREAK;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_inst  = '0;
    chk("exec_retire", 32'(o_retire), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("exec_rst_retire", 32'(o_retire), 32'd0);
    chk("exec_rst_retire_pc", o_retire_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    prog.push_back('{32'h0000_8513, 0, 32'h8000_0000, 1'b1});
    prog.push_back('{EBREAK,        0, 32'h8000_0004, 1'b1});
    run_prog();
    check_halted(32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
